// File: rtl/serial_frame_pkg.sv
// Shared line-level constants and state encodings for the serial frame
// transmitter and its companion receiver.
package serial_frame_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } frame_state_t;

   localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// Bit-period timer: tick is high in the last clock of every CLKS_PER_BIT
// period and the count restarts from zero while clear is held.
module bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   logic [CNT_W-1:0] count;

   // Full-width compare so CLKS_PER_BIT values at a power of two never alias.
   assign tick = (32'(count) == CLKS_PER_BIT - 1);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start bit, DATA_W data bits LSB-first, stop bit,
// each held for CLKS_PER_BIT clocks on a registered, idle-high tx line.
module serial_frame_tx
   import serial_frame_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              load,
   output logic              ready,
   output logic              tx,
   output logic              busy,
   output logic              done
);

   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   frame_state_t      state;
   logic [DATA_W-1:0] shift_reg;
   logic [DATA_W-1:0] shifted;
   logic [IDX_W-1:0]  bit_idx;
   logic              tick;
   logic              last_bit;

   // The timer is held cleared while idle, so every frame starts a fresh period.
   bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk  (clk),
      .reset(reset),
      .clear(state == ST_IDLE),
      .tick (tick)
   );

   assign shifted  = shift_reg >> 1;
   assign last_bit = (32'(bit_idx) == DATA_W - 1);

   // done comes from registered state and the registered timer only.
   assign done = (state == ST_STOP) && tick;

   // tx is loaded one edge ahead with the level of the bit about to be held.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         shift_reg <= '0;
         bit_idx   <= '0;
         tx        <= LINE_IDLE;
         ready     <= 1'b1;
         busy      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (load && ready) begin
                  shift_reg <= data_in;
                  bit_idx   <= '0;
                  tx        <= ~LINE_IDLE;
                  ready     <= 1'b0;
                  busy      <= 1'b1;
                  state     <= ST_START;
               end
            end
            ST_START: begin
               if (tick) begin
                  bit_idx <= '0;
                  tx      <= shift_reg[0];
                  state   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (tick) begin
                  shift_reg <= shifted;
                  if (last_bit) begin
                     bit_idx <= '0;
                     tx      <= LINE_IDLE;
                     state   <= ST_STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     tx      <= shifted[0];
                  end
               end
            end
            ST_STOP: begin
               if (tick) begin
                  ready <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: begin
               tx    <= LINE_IDLE;
               ready <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
